// File: rtl/aq_djpeg_pkg.sv
// Shared types and helpers for the JPEG MCU block-buffer / pixel streamer.
// Holds the write/read FSM state enums, block geometry constants and the output clamp.
package aq_djpeg_pkg;

  typedef enum logic [1:0] {W_Y, W_CB, W_CR} w_state_e;
  typedef enum logic {R_IDLE, R_RUN} r_state_e;

  localparam int BLK_SAMPLES  = 64;
  localparam int MAX_LUMA_BLK = 4;

  // IDCT samples are centred on zero; pixels are unsigned 0..255.
  function automatic logic [7:0] clamp_shift(input logic signed [15:0] v);
    logic signed [15:0] s;
    s = v + 16'sd128;
    if (s < 16'sd0)
      return 8'd0;
    else if (s > 16'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

endpackage

// File: rtl/aq_djpeg_mcu_bank.sv
// NBANK-deep MCU buffer: one 256-sample luma area and two 64-sample chroma areas per bank,
// with synchronous read ports and the count of banks holding a complete MCU.
module aq_djpeg_mcu_bank
  import aq_djpeg_pkg::*;
#(
  parameter  int NBANK  = 2,
  parameter  int DATA_W = 9,
  localparam int BW     = $clog2(NBANK),
  localparam int CW     = $clog2(NBANK + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              wr_en,
  input  w_state_e          wr_sel,
  input  logic [BW-1:0]     wr_bank,
  input  logic [7:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  input  logic              rd_en,
  input  logic [BW-1:0]     rd_bank,
  input  logic [7:0]        rd_luma_addr,
  input  logic [5:0]        rd_chroma_addr,
  output logic [DATA_W-1:0] rd_luma,
  output logic [DATA_W-1:0] rd_cb,
  output logic [DATA_W-1:0] rd_cr,
  input  logic              rd_release,
  output logic [CW-1:0]     full_cnt
);

  logic [DATA_W-1:0] luma_mem [NBANK*MAX_LUMA_BLK*BLK_SAMPLES];
  logic [DATA_W-1:0] cb_mem   [NBANK*BLK_SAMPLES];
  logic [DATA_W-1:0] cr_mem   [NBANK*BLK_SAMPLES];

  // NOTE: the storage arrays have no reset so they map onto block RAM; full_cnt alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel == W_Y)
        luma_mem[{wr_bank, wr_addr}] <= wr_data;
      else if (wr_sel == W_CB)
        cb_mem[{wr_bank, wr_addr[5:0]}] <= wr_data;
      else
        cr_mem[{wr_bank, wr_addr[5:0]}] <= wr_data;
    end
    if (rd_en) begin
      rd_luma <= luma_mem[{rd_bank, rd_luma_addr}];
      rd_cb   <= cb_mem[{rd_bank, rd_chroma_addr}];
      rd_cr   <= cr_mem[{rd_bank, rd_chroma_addr}];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      full_cnt <= '0;
    else if (init)
      full_cnt <= '0;
    else if (wr_commit && !rd_release)
      full_cnt <= full_cnt + CW'(1);
    else if (rd_release && !wr_commit)
      full_cnt <= full_cnt - CW'(1);
  end

endmodule

// File: rtl/aq_djpeg_mcu_stream.sv
// Collects MCU-ordered IDCT blocks into aq_djpeg_mcu_bank and streams upsampled Y/Cb/Cr pixels.
// Build macro AQ_DJPEG_MCU_CROP_EN: pixels outside img_w x img_h are scanned but not emitted.
module aq_djpeg_mcu_stream
  import aq_djpeg_pkg::*;
#(
  parameter int NBANK   = 2,
  parameter int DATA_W  = 9,
  parameter int COORD_W = 16,
  parameter int MCUW_W  = 12
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               init,
  input  logic [2:0]         comp_num,
  input  logic [1:0]         samp_h,
  input  logic [1:0]         samp_v,
  input  logic [MCUW_W-1:0]  mcu_cols,
  input  logic [COORD_W-1:0] img_w,
  input  logic [COORD_W-1:0] img_h,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [7:0]         out_luma,
  output logic [7:0]         out_cb,
  output logic [7:0]         out_cr,
  output logic               mcu_done
);

  localparam int BW = $clog2(NBANK);
  localparam int CW = $clog2(NBANK + 1);

  logic color, h2, v2;
  assign color = (comp_num == 3'd3);
  assign h2    = color && (samp_h == 2'd2);
  assign v2    = color && (samp_v == 2'd2);

  // ---------------- write side ----------------
  w_state_e      w_state, w_state_nxt;
  logic [5:0]    s_cnt, s_cnt_nxt;
  logic [1:0]    blk_cnt, blk_cnt_nxt;
  logic [BW-1:0] wr_ptr;
  logic [CW-1:0] full_cnt;
  logic          in_fire, last_blk, wr_commit;

  assign in_ready = (full_cnt != CW'(NBANK));
  assign in_fire  = in_valid && in_ready;
  assign last_blk = (blk_cnt == {h2 && v2, h2 || v2});

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = w_state;
    s_cnt_nxt   = s_cnt;
    blk_cnt_nxt = blk_cnt;
    wr_commit   = 1'b0;
    if (in_fire) begin
      s_cnt_nxt = s_cnt + 6'd1;
      if (s_cnt == 6'd63) begin
        case (w_state)
          W_Y: begin
            if (!last_blk)
              blk_cnt_nxt = blk_cnt + 2'd1;
            else begin
              blk_cnt_nxt = '0;
              if (color) w_state_nxt = W_CB;
              else       wr_commit   = 1'b1;
            end
          end
          W_CB:    w_state_nxt = W_CR;
          default: begin
            w_state_nxt = W_Y;
            wr_commit   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_Y;
      s_cnt   <= '0;
      blk_cnt <= '0;
      wr_ptr  <= '0;
    end else if (init) begin
      w_state <= W_Y;
      s_cnt   <= '0;
      blk_cnt <= '0;
      wr_ptr  <= '0;
    end else begin
      w_state <= w_state_nxt;
      s_cnt   <= s_cnt_nxt;
      blk_cnt <= blk_cnt_nxt;
      if (wr_commit) wr_ptr <= wr_ptr + BW'(1);
    end
  end

  // ---------------- read scan ----------------
  r_state_e           r_state, r_state_nxt;
  logic [3:0]         px, py, px_nxt, py_nxt, px_end, py_end;
  logic [BW-1:0]      scan_ptr, scan_ptr_nxt;
  logic [MCUW_W-1:0]  mcu_x, mcu_x_nxt;
  logic [COORD_W-1:0] mcu_y, mcu_y_nxt;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               pending, stall, issue, scan_last, scan_vis, rd_release;
  logic [7:0]         rd_luma_addr;
  logic [5:0]         rd_chroma_addr;

  assign px_end    = h2 ? 4'd15 : 4'd7;
  assign py_end    = v2 ? 4'd15 : 4'd7;
  assign scan_last = (px == px_end) && (py == py_end);
  assign issue     = (r_state == R_RUN) && !stall;
  assign scan_x    = (COORD_W'(mcu_x) << (h2 ? 4 : 3)) + COORD_W'(px);
  assign scan_y    = (mcu_y << (v2 ? 4 : 3)) + COORD_W'(py);

  assign rd_luma_addr   = {h2 ? {py[3], px[3]} : {1'b0, py[3]}, py[2:0], px[2:0]};
  assign rd_chroma_addr = {v2 ? py[3:1] : py[2:0], h2 ? px[3:1] : px[2:0]};

`ifdef AQ_DJPEG_MCU_CROP_EN
  assign scan_vis = (scan_x < img_w) && (scan_y < img_h);
`else
  logic unused_crop;
  assign unused_crop = ^{img_w, img_h};
  assign scan_vis    = 1'b1;
`endif

  // A drained-but-unreleased bank is still counted in full_cnt, hence the pending offset.
  always_comb begin
    r_state_nxt  = r_state;
    px_nxt       = px;
    py_nxt       = py;
    scan_ptr_nxt = scan_ptr;
    mcu_x_nxt    = mcu_x;
    mcu_y_nxt    = mcu_y;
    case (r_state)
      R_IDLE: if (full_cnt > CW'(pending)) r_state_nxt = R_RUN;
      default: begin
        if (!stall) begin
          if (scan_last) begin
            px_nxt       = '0;
            py_nxt       = '0;
            scan_ptr_nxt = scan_ptr + BW'(1);
            if (mcu_x == mcu_cols - MCUW_W'(1)) begin
              mcu_x_nxt = '0;
              mcu_y_nxt = mcu_y + COORD_W'(1);
            end else begin
              mcu_x_nxt = mcu_x + MCUW_W'(1);
            end
            if (full_cnt < CW'(2)) r_state_nxt = R_IDLE;
          end else if (px == px_end) begin
            px_nxt = '0;
            py_nxt = py + 4'd1;
          end else begin
            px_nxt = px + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      px       <= '0;
      py       <= '0;
      scan_ptr <= '0;
      mcu_x    <= '0;
      mcu_y    <= '0;
      pending  <= 1'b0;
    end else if (init) begin
      r_state  <= R_IDLE;
      px       <= '0;
      py       <= '0;
      scan_ptr <= '0;
      mcu_x    <= '0;
      mcu_y    <= '0;
      pending  <= 1'b0;
    end else begin
      r_state  <= r_state_nxt;
      px       <= px_nxt;
      py       <= py_nxt;
      scan_ptr <= scan_ptr_nxt;
      mcu_x    <= mcu_x_nxt;
      mcu_y    <= mcu_y_nxt;
      if (issue && scan_last) pending <= 1'b1;
      else if (rd_release)    pending <= 1'b0;
    end
  end

  // ---------------- storage ----------------
  logic [DATA_W-1:0] rd_luma, rd_cb, rd_cr;

  aq_djpeg_mcu_bank #(.NBANK(NBANK), .DATA_W(DATA_W)) u_bank (
    .clk            (clk),
    .rst            (rst),
    .init           (init),
    .wr_en          (in_fire),
    .wr_sel         (w_state),
    .wr_bank        (wr_ptr),
    .wr_addr        ((w_state == W_Y) ? {blk_cnt, s_cnt} : {2'b00, s_cnt}),
    .wr_data        (in_data),
    .wr_commit      (wr_commit),
    .rd_en          (!stall),
    .rd_bank        (scan_ptr),
    .rd_luma_addr   (rd_luma_addr),
    .rd_chroma_addr (rd_chroma_addr),
    .rd_luma        (rd_luma),
    .rd_cb          (rd_cb),
    .rd_cr          (rd_cr),
    .rd_release     (rd_release),
    .full_cnt       (full_cnt)
  );

  // ---------------- output pipeline ----------------
  // Stage 1 aligns scan metadata with the RAM read; stage 2 is the output register.
  logic               s1_tok, s1_vis, s1_last, s2_tok, s2_vis, s2_last;
  logic [COORD_W-1:0] s1_x, s1_y;

  assign out_valid  = s2_tok && s2_vis;
  assign stall      = out_valid && !out_ready;
  assign mcu_done   = s2_tok && s2_last && !stall;
  assign rd_release = mcu_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s1_tok, s1_vis, s1_last, s2_tok, s2_vis, s2_last} <= '0;
      {s1_x, s1_y, out_x, out_y}                          <= '0;
      {out_luma, out_cb, out_cr}                          <= '0;
    end else if (init) begin
      {s1_tok, s1_vis, s1_last, s2_tok, s2_vis, s2_last} <= '0;
      {s1_x, s1_y, out_x, out_y}                          <= '0;
      {out_luma, out_cb, out_cr}                          <= '0;
    end else if (!stall) begin
      s1_tok  <= issue;
      s1_vis  <= scan_vis;
      s1_last <= scan_last;
      s1_x    <= scan_x;
      s1_y    <= scan_y;
      s2_tok  <= s1_tok;
      s2_vis  <= s1_vis;
      s2_last <= s1_last;
      if (s1_tok) begin
        out_x    <= s1_x;
        out_y    <= s1_y;
        out_luma <= clamp_shift(16'(signed'(rd_luma)));
        out_cb   <= color ? clamp_shift(16'(signed'(rd_cb))) : 8'd128;
        out_cr   <= color ? clamp_shift(16'(signed'(rd_cr))) : 8'd128;
      end
    end
  end

endmodule

// File: tb/tb_aq_djpeg_mcu_stream.sv
// Directed self-checking bench for aq_djpeg_mcu_stream (NBANK=2): 444, 420, grayscale,
// backpressure with full banks, and init mid-write; crop case only with AQ_DJPEG_MCU_CROP_EN.
module tb_aq_djpeg_mcu_stream;

  localparam int NBANK = 2, DATA_W = 9, COORD_W = 16, MCUW_W = 12;

  logic               rst = 1'b0, clk = 1'b0, init = 1'b0;
  logic [2:0]         comp_num = 3'd3;
  logic [1:0]         samp_h = 2'd1, samp_v = 2'd1;
  logic [MCUW_W-1:0]  mcu_cols = 12'd2;
  logic [COORD_W-1:0] img_w = 16'hFFFF, img_h = 16'hFFFF;
  logic               in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic               out_valid, out_ready = 1'b0;
  logic [COORD_W-1:0] out_x, out_y;
  logic [7:0]         out_luma, out_cb, out_cr;
  logic               mcu_done;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  l;
    logic [7:0]  cb;
    logic [7:0]  cr;
  } pix_t;

  pix_t  cap[$];
  int    done_cnt = 0;
  int    tests = 0, fails = 0;
  int    base, db, err, mx, my;
  pix_t  p, snap;
  logic  seen [256];

  aq_djpeg_mcu_stream #(.NBANK(NBANK), .DATA_W(DATA_W), .COORD_W(COORD_W), .MCUW_W(MCUW_W)) dut (
    .rst(rst), .clk(clk), .init(init), .comp_num(comp_num), .samp_h(samp_h), .samp_v(samp_v),
    .mcu_cols(mcu_cols), .img_w(img_w), .img_h(img_h), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_luma(out_luma), .out_cb(out_cb), .out_cr(out_cr), .mcu_done(mcu_done)
  );

  always #5 clk = ~clk;

  // Capture accepted pixels just after inputs settle on the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready)
      cap.push_back(pix_t'{x: out_x, y: out_y, l: out_luma, cb: out_cb, cr: out_cr});
    if (mcu_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    for (int t = 0; t < 3000 && !in_ready; t++) @(negedge clk);
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout observed in_ready=%0b expected 1", in_ready);
      $fatal(1, "input stalled");
    end
    @(negedge clk);
  endtask

  task automatic send_const(input int v);
    for (int s = 0; s < 64; s++) send(v);
  endtask

  task automatic do_init();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic wait_pix(input int n);
    for (int t = 0; t < 4000 && (cap.size() - base) < n; t++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  function automatic pix_t get_pix(input int x, input int y);
    pix_t r = '1;
    for (int i = base; i < cap.size(); i++)
      if (int'(cap[i].x) == x && int'(cap[i].y) == y) r = cap[i];
    return r;
  endfunction

  function automatic int max_x();
    int m = -1;
    for (int i = base; i < cap.size(); i++) if (int'(cap[i].x) > m) m = int'(cap[i].x);
    return m;
  endfunction

  function automatic int max_y();
    int m = -1;
    for (int i = base; i < cap.size(); i++) if (int'(cap[i].y) > m) m = int'(cap[i].y);
    return m;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_luma", out_luma, 0);
    check("rst_out_x", out_x, 0);
    check("rst_mcu_done", mcu_done, 0);

    // 444, two MCUs across one MCU row
    out_ready = 1'b1;
    base = cap.size(); db = done_cnt;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 64; s++) send(s);
      send_const(-128);
      send_const(127);
    end
    in_valid = 1'b0;
    wait_pix(128);
    check("t444_count", cap.size() - base, 128);
    check("t444_done", done_cnt - db, 2);
    p = get_pix(9, 0);
    check("t444_9_0_luma", p.l, 129);
    check("t444_9_0_cb", p.cb, 0);
    check("t444_9_0_cr", p.cr, 255);
    p = get_pix(15, 7);
    check("t444_15_7_luma", p.l, 191);

    // 420 with Cb = sample index, Y block b = 20*b
    do_init();
    samp_h = 2'd2; samp_v = 2'd2; mcu_cols = 12'd1;
    base = cap.size(); db = done_cnt;
    for (int b = 0; b < 4; b++) send_const(b * 20);
    for (int s = 0; s < 64; s++) send(s);
    send_const(0);
    in_valid = 1'b0;
    wait_pix(256);
    check("t420_count", cap.size() - base, 256);
    check("t420_done", done_cnt - db, 1);
    p = get_pix(0, 0); check("t420_0_0_cb", p.cb, 128);
    p = get_pix(1, 0); check("t420_1_0_cb", p.cb, 128);
    p = get_pix(0, 1); check("t420_0_1_cb", p.cb, 128);
    p = get_pix(1, 1); check("t420_1_1_cb", p.cb, 128);
    p = get_pix(2, 0); check("t420_2_0_cb", p.cb, 129);
    p = get_pix(15, 15);
    check("t420_15_15_cb", p.cb, 191);
    check("t420_15_15_luma", p.l, 188);
    p = get_pix(8, 0); check("t420_8_0_luma", p.l, 148);
    p = get_pix(0, 8); check("t420_0_8_luma", p.l, 168);
    check("t420_max_x", max_x(), 15);
    check("t420_max_y", max_y(), 15);

    // Grayscale: sampling forced to 1, chroma fixed at 128
    do_init();
    comp_num = 3'd1; mcu_cols = 12'd4;
    base = cap.size(); db = done_cnt;
    send_const(-200);
    in_valid = 1'b0;
    wait_pix(64);
    check("gray_count", cap.size() - base, 64);
    check("gray_done", done_cnt - db, 1);
    p = get_pix(7, 7);
    check("gray_luma", p.l, 0);
    check("gray_cb", p.cb, 128);
    check("gray_cr", p.cr, 128);
    check("gray_max_x", max_x(), 7);

    // Backpressure: both banks fill while the output is blocked
    do_init();
    comp_num = 3'd3; samp_h = 2'd1; samp_v = 2'd1; mcu_cols = 12'd2;
    out_ready = 1'b0;
    base = cap.size(); db = done_cnt;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 64; s++) send(s + m * 64 - 96);
      send_const(m);
      send_const(-m);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_valid_blocked", out_valid, 1);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    snap = pix_t'{x: out_x, y: out_y, l: out_luma, cb: out_cb, cr: out_cr};
    check("bp_stall_x", snap.x, 4);
    check("bp_stall_y", snap.y, 2);
    check("bp_stall_luma", snap.l, 52);
    err = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || pix_t'{x: out_x, y: out_y, l: out_luma, cb: out_cb, cr: out_cr} !== snap) err++;
    end
    check("bp_hold_stable", err, 0);
    check("bp_in_ready_still_low", in_ready, 0);
    out_ready = 1'b1;
    for (int s = 0; s < 64; s++) send(s + 128 - 96);
    send_const(2);
    send_const(-2);
    in_valid = 1'b0;
    wait_pix(192);
    check("bp_count", cap.size() - base, 192);
    check("bp_done", done_cnt - db, 3);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    err = 0;
    for (int i = base; i < cap.size(); i++) begin
      mx = int'(cap[i].x); my = int'(cap[i].y);
      if (mx > 15 || my > 15 || seen[my * 16 + mx]) err++;
      else begin
        seen[my * 16 + mx] = 1'b1;
        if (int'(cap[i].l) != (my % 8) * 8 + (mx % 8) + ((my / 8) * 2 + mx / 8) * 64 + 32) err++;
      end
    end
    check("bp_pixel_model", err, 0);

    // init part-way through block 2 of a 420 MCU
    do_init();
    samp_h = 2'd2; samp_v = 2'd2; mcu_cols = 12'd1;
    send_const(1);
    send_const(2);
    for (int s = 0; s < 30; s++) send(3);
    in_valid = 1'b0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("init_in_ready", in_ready, 1);
    check("init_out_valid", out_valid, 0);
    samp_h = 2'd1; samp_v = 2'd1; mcu_cols = 12'd2;
    base = cap.size(); db = done_cnt;
    send_const(5);
    send_const(0);
    send_const(0);
    in_valid = 1'b0;
    wait_pix(64);
    check("init_count", cap.size() - base, 64);
    check("init_done", done_cnt - db, 1);
    check("init_first_x", cap[base].x, 0);
    check("init_first_y", cap[base].y, 0);
    check("init_first_luma", cap[base].l, 133);

`ifdef AQ_DJPEG_MCU_CROP_EN
    // Crop to 10x5 across two 444 MCUs
    do_init();
    img_w = 16'd10; img_h = 16'd5;
    base = cap.size(); db = done_cnt;
    for (int m = 0; m < 2; m++) begin
      send_const(0);
      send_const(0);
      send_const(0);
    end
    in_valid = 1'b0;
    wait_pix(50);
    check("crop_count", cap.size() - base, 50);
    check("crop_done", done_cnt - db, 2);
    check("crop_max_x", max_x(), 9);
    check("crop_max_y", max_y(), 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
